// File: rtl/pattern_pkg.sv
// Shared types and helpers for the serial pattern sender and the detectors it feeds.
package pattern_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} sender_state_t;

  localparam logic IDLE_LEVEL = 1'b0;

  // Zero-extended words keep the same parity, so callers widen to 32 bits.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pattern_sender_piso_shreg.sv
// Parallel-in/serial-out shift register, MSB-first, refilled with the line idle level.
module piso_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);
  import pattern_pkg::*;

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!reset)
      sr <= '0;
    else if (load)
      sr <= din;
    else if (shift)
      sr <= {sr[WIDTH-2:0], IDLE_LEVEL};
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/pattern_sender.sv
// Serial pattern transmitter: valid/ready word load, MSB-first shift-out on A, idle gap.
// Optional trailing even-parity bit when PATTERN_SENDER_PARITY_EN is defined.
//
//   state | meaning
//   IDLE  | load_ready high, A at idle level, waiting for load_valid
//   SEND  | one word bit (then parity, if built in) per cycle on A
//   GAP   | A at idle level for GAP cycles before the next word
module pattern_sender #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             A,
  output logic             tx_active,
  output logic             done
);
  import pattern_pkg::*;

`ifdef PATTERN_SENDER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  sender_state_t   state, state_d;
  logic [BW-1:0]   bit_cnt, bit_cnt_d;
  logic [GW-1:0]   gap_cnt, gap_cnt_d;
  logic            a_q, a_d;
  logic            accept, last, sh_msb, next_bit;

  assign accept = (state == IDLE) && load_valid;
  assign last   = (state == SEND) && (bit_cnt == BIT_LAST);

  // The shift register holds the bits still to come; the first bit goes straight to a_q.
  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == SEND),
    .din   ({load_data[WIDTH-2:0], IDLE_LEVEL}),
    .msb   (sh_msb)
  );

`ifdef PATTERN_SENDER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!reset)
      par_q <= 1'b0;
    else if (accept)
      par_q <= even_parity(32'(load_data));
  end

  assign next_bit = (bit_cnt == BW'(WIDTH - 1)) ? par_q : sh_msb;
`else
  assign next_bit = sh_msb;
`endif

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    a_d       = IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          bit_cnt_d = '0;
          a_d       = load_data[WIDTH-1];
        end
      end
      SEND: begin
        if (last) begin
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          if (GAP > 0)
            state_d = pattern_pkg::GAP;
          else
            state_d = IDLE;
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
          a_d       = next_bit;
        end
      end
      pattern_pkg::GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      a_q     <= IDLE_LEVEL;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      gap_cnt <= gap_cnt_d;
      a_q     <= a_d;
    end
  end

  assign A          = a_q;
  assign load_ready = (state == IDLE);
  assign tx_active  = (state == SEND);
  assign done       = last;

endmodule
